// File: rtl/serial_word_deserializer.sv
// Bit-serial receiver: assembles WIDTH-bit words, presents them on a valid/ready port.
// Optional even-parity frame bit and parity_err port: SERIAL_WORD_DESERIALIZER_PARITY_EN.
module serial_word_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_t;

  hold_t            r_hold;
  hold_t            w_hold_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] r_o;
  logic             w_last;
  logic             w_acc;
  logic             w_done;
  logic             w_data;

  assign w_last    = (r_cnt == LAST);
  assign O_valid   = (r_hold == HOLD_FULL);
  assign O         = r_o;
  // Only the frame-final bit can stall, and only while the held word is stuck.
  assign bit_ready = !(w_last && O_valid && !O_ready);
  assign w_acc     = bit_valid && bit_ready;
  assign w_done    = w_acc && w_last;

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  logic r_par;
  logic r_perr;

  assign w_data     = !w_last;
  assign parity_err = r_perr;

  // Running XOR of the frame; the check result is latched with the word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_acc) begin
      r_par <= w_last ? 1'b0 : (r_par ^ bit_in);
      if (w_last)
        r_perr <= r_par ^ bit_in;
    end
  end
`else
  assign w_data = 1'b1;
`endif

  // Shift data bits in so that after WIDTH shifts the first bit sits at its slot.
  always_comb begin
    w_sh_nxt = r_sh;
    if (w_data) begin
      if (MSB_FIRST)
        w_sh_nxt = {r_sh[WIDTH-2:0], bit_in};
      else
        w_sh_nxt = {bit_in, r_sh[WIDTH-1:1]};
    end
  end

  // Holding-register occupancy: state register.
  always_ff @(posedge CLK) begin
    if (RESET)
      r_hold <= HOLD_EMPTY;
    else
      r_hold <= w_hold_nxt;
  end

  // Holding-register occupancy: a completed frame refills it even while draining.
  always_comb begin
    w_hold_nxt = r_hold;
    case (r_hold)
      HOLD_EMPTY: if (w_done) w_hold_nxt = HOLD_FULL;
      HOLD_FULL: begin
        if (w_done)
          w_hold_nxt = HOLD_FULL;
        else if (O_ready)
          w_hold_nxt = HOLD_EMPTY;
      end
      default: w_hold_nxt = HOLD_EMPTY;
    endcase
  end

  // Bit counter, shift register and output word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_sh  <= '0;
      r_o   <= '0;
    end else if (w_acc) begin
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
      r_sh  <= w_last ? '0 : w_sh_nxt;
      if (w_last)
        r_o <= w_sh_nxt;
    end
  end

endmodule
